// File: rtl/approx_adder_err_engine.sv
// Error characterisation engine: issues LFSR operand pairs to an external adder and scores its sums.
// Latency: one pair per cycle; compare LAT cycles after issue; done_o one cycle after last compare.
// No backpressure (adder must accept every pair). Optional max-ED tracking under ERR_MAX_TRACK_EN.
module approx_adder_err_engine #(
    parameter int N     = 16,
    parameter int LAT   = 1,
    parameter int CNT_W = 24,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_tests_i,
    input  logic [31:0]      seed_i,
    output logic [N-1:0]     op_a_o,
    output logic [N-1:0]     op_b_o,
    output logic             op_vld_o,
    input  logic [N-1:0]     approx_sum_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [ACC_W-1:0] sum_ed_o,
    output logic [N-1:0]     max_ed_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT > 0 ? LAT - 1 : 0);
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    state_t           state;
    state_t           next_state;
    logic [31:0]      lfsr_a;
    logic [31:0]      lfsr_b;
    logic [CNT_W-1:0] remaining;
    logic [DW-1:0]    drain_cnt;
    logic             accept;
    logic             last_issue;
    logic [N-1:0]     exact_now;
    logic             cmp_vld;
    logic [N-1:0]     cmp_exact;
    logic [N-1:0]     ed;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_sat;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
    endfunction

    assign accept     = (state == S_IDLE) && start_i;
    assign last_issue = (state == S_RUN) && (remaining == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    next_state = (num_tests_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    next_state = (LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        op_vld_o = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state)
            S_RUN: begin
                op_vld_o = 1'b1;
                busy_o   = 1'b1;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                op_vld_o = 1'b0;
            end
        endcase
    end

    assign op_a_o    = lfsr_a[N-1:0];
    assign op_b_o    = lfsr_b[N-1:0];
    assign exact_now = op_a_o + op_b_o;

    // Exact sum rides alongside the valid so the compare lines up with the adder's result.
    generate
        if (LAT == 0) begin : g_no_dly
            assign cmp_vld   = op_vld_o;
            assign cmp_exact = exact_now;
        end else begin : g_dly
            logic [LAT-1:0] vld_dly;
            logic [N-1:0]   sum_dly [LAT];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_dly <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        sum_dly[i] <= '0;
                    end
                end else begin
                    vld_dly[0] <= op_vld_o;
                    sum_dly[0] <= exact_now;
                    for (int i = 1; i < LAT; i++) begin
                        vld_dly[i] <= vld_dly[i-1];
                        sum_dly[i] <= sum_dly[i-1];
                    end
                end
            end

            assign cmp_vld   = vld_dly[LAT-1];
            assign cmp_exact = sum_dly[LAT-1];
        end
    endgenerate

    always_comb begin
        ed = (approx_sum_i > cmp_exact) ? (approx_sum_i - cmp_exact)
                                        : (cmp_exact - approx_sum_i);
    end

    // One extra bit catches the carry so the accumulator pins at all-ones instead of wrapping.
    assign sum_ext = {1'b0, sum_ed_o} + {{(ACC_W + 1 - N){1'b0}}, ed};
    assign sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_a    <= '0;
            lfsr_b    <= '0;
            remaining <= '0;
            err_cnt_o <= '0;
            sum_ed_o  <= '0;
        end else if (accept) begin
            lfsr_a    <= (seed_i == 32'h0) ? 32'h1 : seed_i;
            lfsr_b    <= (seed_i == 32'hFFFF_FFFF) ? 32'h1 : ~seed_i;
            remaining <= num_tests_i;
            err_cnt_o <= '0;
            sum_ed_o  <= '0;
        end else begin
            if (op_vld_o) begin
                lfsr_a    <= lfsr_step(lfsr_a);
                lfsr_b    <= lfsr_step(lfsr_b);
                remaining <= remaining - CNT_W'(1);
            end
            if (cmp_vld && (ed != '0)) begin
                err_cnt_o <= err_cnt_o + CNT_W'(1);
                sum_ed_o  <= sum_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (state != S_DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + DW'(1);
        end
    end

`ifdef ERR_MAX_TRACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_ed_o <= '0;
        end else if (accept) begin
            max_ed_o <= '0;
        end else if (cmp_vld && (ed > max_ed_o)) begin
            max_ed_o <= ed;
        end
    end
`else
    assign max_ed_o = '0;
`endif

endmodule

// File: tb/tb_approx_adder_err_engine.sv
// Randomised bench: registered approximate adder plus a plain-arithmetic reference of the scoring rules.
module tb_approx_adder_err_engine;

    localparam int N     = 16;
    localparam int LAT   = 1;
    localparam int CNT_W = 24;
    localparam int ACC_W = 48;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_tests;
    logic [31:0]      seed;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic             op_vld;
    logic [N-1:0]     approx_sum;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic [ACC_W-1:0] sum_ed;
    logic [N-1:0]     max_ed;

    int tests = 0;
    int fails = 0;
    int mode  = 0;
    int last_err;
    longint last_sum;
    int last_max;

    approx_adder_err_engine #(.N(N), .LAT(LAT), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .num_tests_i  (num_tests),
        .seed_i       (seed),
        .op_a_o       (op_a),
        .op_b_o       (op_b),
        .op_vld_o     (op_vld),
        .approx_sum_i (approx_sum),
        .busy_o       (busy),
        .done_o       (done),
        .err_cnt_o    (err_cnt),
        .sum_ed_o     (sum_ed),
        .max_ed_o     (max_ed)
    );

    always #5 clk = ~clk;

    // 0 exact, 1 flip lsb, 2 flip msb, 3 lower-part-OR adder (4 low bits ORed, no carry in)
    function automatic logic [N-1:0] approx_fn(input logic [N-1:0] a, input logic [N-1:0] b, input int m);
        logic [N-1:0]  ex;
        logic [11:0]   hi;
        ex = a + b;
        hi = a[15:4] + b[15:4];
        case (m)
            1:       return ex ^ 16'h0001;
            2:       return ex ^ 16'h8000;
            3:       return {hi, a[3:0] | b[3:0]};
            default: return ex;
        endcase
    endfunction

    always @(posedge clk) approx_sum <= approx_fn(op_a, op_b, mode);

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int num, input logic [31:0] sd, input int m, input int glitch_k);
        logic [31:0] la, lb;
        logic [N-1:0] ex, ap;
        int d, exp_err, exp_max, done_k;
        longint exp_sum;
        mode    = m;
        la      = (sd == 32'h0) ? 32'h1 : sd;
        lb      = (sd == 32'hFFFF_FFFF) ? 32'h1 : ~sd;
        exp_err = 0;
        exp_sum = 0;
        exp_max = 0;
        done_k  = (num == 0) ? 1 : num + LAT + 1;
        @(negedge clk);
        start     = 1'b1;
        num_tests = CNT_W'(num);
        seed      = sd;
        @(posedge clk);
        #1;
        start     = 1'b0;
        num_tests = CNT_W'($urandom);
        seed      = $urandom;
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk);
            check("op_vld", {63'd0, op_vld}, {63'd0, k <= num});
            check("busy", {63'd0, busy}, {63'd0, (num > 0) && (k <= num + LAT)});
            check("done", {63'd0, done}, {63'd0, k == done_k});
            if (k <= num) begin
                if (k == 1 && sd == 32'h0) check("seed0_op_a", {48'd0, op_a}, 64'd1);
                if (k == 1 && sd == 32'hFFFF_FFFF) check("seedf_op_b", {48'd0, op_b}, 64'd1);
                check("op_a", {48'd0, op_a}, {48'd0, la[N-1:0]});
                check("op_b", {48'd0, op_b}, {48'd0, lb[N-1:0]});
                ex = la[N-1:0] + lb[N-1:0];
                ap = approx_fn(la[N-1:0], lb[N-1:0], m);
                d  = int'(ap) - int'(ex);
                if (d < 0) d = -d;
                if (d != 0) exp_err++;
                exp_sum += d;
                if (d > exp_max) exp_max = d;
                la = lfsr_next(la);
                lb = lfsr_next(lb);
            end
            start = (glitch_k > 0) && (k == glitch_k || k == done_k);
            if (start) begin
                num_tests = CNT_W'($urandom);
                seed      = $urandom;
            end
        end
`ifndef ERR_MAX_TRACK_EN
        exp_max = 0;
`endif
        check("err_cnt", {40'd0, err_cnt}, 64'(exp_err));
        check("sum_ed", {16'd0, sum_ed}, 64'(exp_sum));
        check("max_ed", {48'd0, max_ed}, 64'(exp_max));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("hold_err", {40'd0, err_cnt}, 64'(exp_err));
        check("hold_sum", {16'd0, sum_ed}, 64'(exp_sum));
        check("hold_idle", {61'd0, done, busy, op_vld}, 64'd0);
        last_err = exp_err;
        last_sum = exp_sum;
        last_max = exp_max;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_tests = '0;
        seed      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {61'd0, done, busy, op_vld}, 64'd0);
        check("rst_err", {40'd0, err_cnt}, 64'd0);
        check("rst_sum", {16'd0, sum_ed}, 64'd0);
        check("rst_max", {48'd0, max_ed}, 64'd0);
        check("rst_ops", {32'd0, op_a, op_b}, 64'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_vld", {62'd0, busy, op_vld}, 64'd0);
        end

        run(1000, 32'h1234_5678, 0, 0);
        check("exact_err", 64'(last_err), 64'(err_cnt));
        check("exact_err_c", {40'd0, err_cnt}, 64'd0);
        check("exact_sum_c", {16'd0, sum_ed}, 64'd0);

        run(500, $urandom, 1, 0);
        check("lsb_err_c", {40'd0, err_cnt}, 64'd500);
        check("lsb_sum_c", {16'd0, sum_ed}, 64'd500);
`ifdef ERR_MAX_TRACK_EN
        check("lsb_max_c", {48'd0, max_ed}, 64'd1);
`endif

        run(10, $urandom, 2, 0);
        check("msb_err_c", {40'd0, err_cnt}, 64'd10);
        check("msb_sum_c", {16'd0, sum_ed}, 64'd327680);
`ifdef ERR_MAX_TRACK_EN
        check("msb_max_c", {48'd0, max_ed}, 64'd32768);
`endif

        run(0, $urandom, 3, 0);
        check("zero_err_c", {40'd0, err_cnt}, 64'd0);
        check("zero_sum_c", {16'd0, sum_ed}, 64'd0);

        run(5, 32'h0, 3, 0);
        run(5, 32'hFFFF_FFFF, 3, 0);
        run(50, $urandom, 3, 20);

        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 200);
            run(n, $urandom, 3, (r % 2 == 1) ? $urandom_range(1, n) : 0);
        end

        @(negedge clk);
        start     = 1'b1;
        num_tests = CNT_W'(100);
        seed      = $urandom;
        mode      = 3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_flags", {61'd0, done, busy, op_vld}, 64'd0);
        check("mid_rst_err", {40'd0, err_cnt}, 64'd0);
        check("mid_rst_sum", {16'd0, sum_ed}, 64'd0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_quiet", {62'd0, done, busy}, 64'd0);
        end
        run(30, $urandom, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
